// File: rtl/pwm_div_pkg.sv
// Shared types and sizing for the PWM divider controller and its prescaler.
package pwm_div_pkg;

  localparam int CNT_W = 16;
  localparam int DIV_W = 3;
  localparam int PRE_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Terminal prescaler count for a divider select: 2**div - 1, built bitwise so div=7 needs no wider math.
  function automatic logic [PRE_W-1:0] div_limit(input logic [DIV_W-1:0] div);
    logic [PRE_W-1:0] m;
    m = '0;
    for (int i = 0; i < PRE_W; i++) begin
      if (i < int'(div)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: one-cycle tick every 2**div_act clocks while run is high, combinational tick.
// No backpressure; counter is held at zero whenever run is low.
module pwm_prescaler
  import pwm_div_pkg::*;
#(
  parameter int DIV_W = pwm_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_act,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = run && (pre_cnt == div_limit(div_act));

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_div_ctrl.sv
// PWM sequencer with double-buffered div/period/duty; pwm_out first high the cycle after LOAD exits.
// No backpressure; configuration is only sampled at LOAD or a period boundary.
module pwm_div_ctrl
  import pwm_div_pkg::*;
#(
  parameter int CNT_W = pwm_div_pkg::CNT_W,
  parameter int DIV_W = pwm_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out,
  output logic             tick,
  output logic             period_end,
  output logic             busy,
  output logic             cfg_err,
  output logic [DIV_W-1:0] active_div
);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_act;
  logic [CNT_W-1:0] period_act, duty_act, pwm_cnt, pwm_cnt_nxt, duty_nxt;
  logic             running, running_nxt, load_now, cfg_bad, reload, pwm_out_nxt;

  assign running = (state == RUN) || (state == STOP);

  pwm_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk     (clk),
    .reset   (reset),
    .run     (running),
    .div_act (div_act),
    .tick    (tick)
  );

  assign period_end = tick && (pwm_cnt == period_act - CNT_W'(1));
  assign load_now   = (state == LOAD) || period_end;
  assign cfg_bad    = (period == '0);
  assign reload     = load_now && !cfg_bad;
  assign cfg_err    = load_now && cfg_bad;
  assign duty_nxt   = reload ? duty : duty_act;
  assign busy       = (state != IDLE);
  assign active_div = div_act;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = LOAD;
      LOAD: state_nxt = cfg_bad ? IDLE : RUN;
      RUN: begin
        if (!enable) state_nxt = period_end ? IDLE : STOP;
      end
      STOP: begin
        // Re-enable wins over the boundary so the waveform carries on without a gap.
        if (enable)          state_nxt = RUN;
        else if (period_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pwm_cnt_nxt = pwm_cnt;
    if (!running || period_end) begin
      pwm_cnt_nxt = '0;
    end else if (tick) begin
      pwm_cnt_nxt = pwm_cnt + CNT_W'(1);
    end
    running_nxt = (state_nxt == RUN) || (state_nxt == STOP);
    pwm_out_nxt = running_nxt && (pwm_cnt_nxt < duty_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pwm_cnt    <= '0;
      pwm_out    <= 1'b0;
      div_act    <= '0;
      period_act <= '0;
      duty_act   <= '0;
    end else begin
      state   <= state_nxt;
      pwm_cnt <= pwm_cnt_nxt;
      pwm_out <= pwm_out_nxt;
      if (reload) begin
        div_act    <= div_sel;
        period_act <= period;
        duty_act   <= duty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_div_ctrl.sv
// Self-checking bench for pwm_div_ctrl: table of configurations plus hand-written corner sequences.
module tb_pwm_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  div_sel;
  logic [15:0] period;
  logic [15:0] duty;
  logic        pwm_out, tick, period_end, busy, cfg_err;
  logic [2:0]  active_div;

  int n_total  = 0;
  int n_passed = 0;
  int exp_q[$];

  typedef struct {
    logic [2:0]  div;
    logic [15:0] per;
    logic [15:0] dut;
    int          exp_clks;
    int          exp_high;
  } vec_t;

  vec_t vecs[7];

  pwm_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_sel    (div_sel),
    .period     (period),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .tick       (tick),
    .period_end (period_end),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic sb_check(input string name, input int act);
    int e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got %0d, scoreboard empty", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_pe();
    int found;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (period_end) found = 1;
    end
    check("wait_period_end", found, 1);
  endtask

  // Samples one full period starting right after a period_end; optionally changes duty/enable mid-way.
  task automatic measure(input int chg_at, input logic [15:0] nduty, input logic nen,
                         output int clks, output int highs, output int ticks,
                         output int busy_end, output int err_end);
    int done;
    clks = 0; highs = 0; ticks = 0; busy_end = 0; err_end = 0; done = 0;
    for (int i = 0; i < 2000 && done == 0; i++) begin
      @(negedge clk);
      clks++;
      if (pwm_out) highs++;
      if (tick) ticks++;
      if (period_end) begin
        done     = 1;
        busy_end = int'(busy);
        err_end  = int'(cfg_err);
      end else if (clks == chg_at) begin
        duty   = nduty;
        enable = nen;
      end
    end
    check("measure_period_end", done, 1);
  endtask

  initial begin
    int clks, highs, ticks, bsy, err, cnt;

    vecs[0] = '{3'd0, 16'd4,  16'd1, 4,  1};
    vecs[1] = '{3'd2, 16'd10, 16'd5, 40, 20};
    vecs[2] = '{3'd1, 16'd3,  16'd0, 6,  0};
    vecs[3] = '{3'd0, 16'd5,  16'd7, 5,  5};
    vecs[4] = '{3'd3, 16'd2,  16'd1, 16, 8};
    vecs[5] = '{3'd0, 16'd1,  16'd1, 1,  1};
    vecs[6] = '{3'd2, 16'd6,  16'd6, 24, 24};

    reset = 1'b1; enable = 1'b0; div_sel = '0; period = '0; duty = '0;
    repeat (2) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Reset asserted mid-RUN
    div_sel = 3'd2; period = 16'd10; duty = 16'd5; enable = 1'b1;
    repeat (12) @(negedge clk);
    check("run_active_div", int'(active_div), 2);
    check("run_busy", int'(busy), 1);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("midrun_reset_pwm_out", int'(pwm_out), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_tick", int'(tick), 0);
    check("midrun_reset_active_div", int'(active_div), 0);
    reset = 1'b0;

    // Start-up latency: LOAD cycle, then pwm_out high in the first RUN cycle
    do_reset();
    div_sel = 3'd0; period = 16'd4; duty = 16'd1; enable = 1'b1;
    @(negedge clk);
    check("load_busy", int'(busy), 1);
    check("load_pwm_out", int'(pwm_out), 0);
    check("load_tick", int'(tick), 0);
    @(negedge clk);
    check("first_run_pwm_out", int'(pwm_out), 1);
    check("first_run_tick", int'(tick), 1);
    check("first_run_period_end", int'(period_end), 0);

    // Table-driven configurations
    for (int v = 0; v < 7; v++) begin
      do_reset();
      div_sel = vecs[v].div; period = vecs[v].per; duty = vecs[v].dut;
      exp_q.push_back(vecs[v].exp_clks);
      exp_q.push_back(vecs[v].exp_high);
      exp_q.push_back(int'(vecs[v].per));
      exp_q.push_back(int'(vecs[v].div));
      enable = 1'b1;
      wait_pe();
      measure(0, duty, 1'b1, clks, highs, ticks, bsy, err);
      sb_check($sformatf("vec%0d_period_clks", v), clks);
      sb_check($sformatf("vec%0d_high_clks", v), highs);
      sb_check($sformatf("vec%0d_ticks", v), ticks);
      sb_check($sformatf("vec%0d_active_div", v), int'(active_div));
    end

    // Mid-period duty change applies only from the next period
    do_reset();
    div_sel = 3'd0; period = 16'd8; duty = 16'd2; enable = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(6);
    wait_pe();
    measure(4, 16'd6, 1'b1, clks, highs, ticks, bsy, err);
    sb_check("duty_change_cur_high", highs);
    measure(0, duty, 1'b1, clks, highs, ticks, bsy, err);
    sb_check("duty_change_next_high", highs);

    // period=0 at a running boundary: cfg_err, old config kept
    do_reset();
    div_sel = 3'd0; period = 16'd4; duty = 16'd1; enable = 1'b1;
    wait_pe();
    period = 16'd0;
    measure(0, duty, 1'b1, clks, highs, ticks, bsy, err);
    check("bad_boundary_cfg_err", err, 1);
    measure(0, duty, 1'b1, clks, highs, ticks, bsy, err);
    check("bad_boundary_kept_period", clks, 4);
    check("bad_boundary_kept_high", highs, 1);

    // period=0 at LOAD: single cfg_err pulse, back to IDLE
    do_reset();
    div_sel = 3'd0; period = 16'd0; duty = 16'd3; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("load_zero_cfg_err", int'(cfg_err), 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cfg_err || pwm_out || busy) cnt++;
    end
    check("load_zero_quiet_after", cnt, 0);

    // Enable dropped at tick 3: period finishes high, then IDLE
    do_reset();
    div_sel = 3'd0; period = 16'd8; duty = 16'd8; enable = 1'b1;
    wait_pe();
    measure(4, 16'd8, 1'b0, clks, highs, ticks, bsy, err);
    check("stop_period_clks", clks, 8);
    check("stop_period_high", highs, 8);
    check("stop_busy_at_end", bsy, 1);
    @(negedge clk);
    check("stop_busy_after", int'(busy), 0);
    check("stop_pwm_after", int'(pwm_out), 0);

    // Re-enable while in STOP: no gap
    do_reset();
    div_sel = 3'd0; period = 16'd8; duty = 16'd8; enable = 1'b1;
    wait_pe();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_state_busy", int'(busy), 1);
    enable = 1'b1;
    cnt = 0; ticks = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (!pwm_out) cnt++;
      if (period_end) ticks++;
    end
    check("reenable_low_cycles", cnt, 0);
    check("reenable_period_ends", ticks, 3);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
